// File: rtl/seq_shift_add_mul_pkg.sv
// Shared constants for the shift-add multiplier.
// State encoding and default sizing.
package seq_shift_add_mul_pkg;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNT_W = 7;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_add_shift_step.sv
// One radix-2 shift-add iteration.
// Adds mcand to the upper half when acc[0] is set, then shifts right.
module mul_add_shift_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;

  // Carry out of the add lands in the top bit after the shift.
  always_comb begin
    sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    if (acc_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    acc_o = {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative unsigned multiplier, one partial product per clock.
// Fixed WIDTH-cycle latency, level start, clear acts like reset.
module seq_shift_add_mul
  import seq_shift_add_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               op_start,
  input  logic               op_clear,
  output logic               op_done,
  output logic               busy,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  mul_add_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .acc_o  (acc_step)
  );

  // Next-state: clear beats everything, then the FSM.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = MUL_IDLE;
      acc_d    = '0;
      mcand_d  = '0;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (op_start) begin
            acc_d   = {{WIDTH{1'b0}}, multiplier};
            mcand_d = multiplicand;
            cnt_d   = '0;
            state_d = MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_d = acc_step;
            state_d  = MUL_DONE;
          end
        end
        MUL_DONE: begin
          state_d = MUL_DONE;
        end
        default: begin
          state_d = MUL_IDLE;
        end
      endcase
    end
    done_d = (state_d == MUL_DONE);
    busy_d = (state_d == MUL_BUSY);
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign op_done = done_q;
  assign busy    = busy_q;
  assign result  = result_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Scoreboard bench for seq_shift_add_mul.
// Driver pushes a*b and due cycle; monitor pops on op_done.
module tb_seq_shift_add_mul;

  localparam int W = 64;

  typedef struct {
    logic [2*W-1:0] res;
    int             due;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   multiplicand;
  logic           op_start;
  logic           op_clear;
  logic           op_done;
  logic           busy;
  logic [2*W-1:0] result;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;
  logic done_prev = 1'b0;

  seq_shift_add_mul dut (
    .clk         (clk),
    .reset       (reset),
    .multiplier  (multiplier),
    .multiplicand(multiplicand),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .op_done     (op_done),
    .busy        (busy),
    .result      (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string          name,
    input logic [2*W-1:0] act,
    input logic [2*W-1:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && op_done) begin
        tests++;
        fails++;
        $display("FAIL excl: busy and op_done both 1");
      end
      if (!op_done) begin
        chk("result_idle", result, '0);
      end
      if (op_done && !done_prev) begin
        n_done++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got %0h want none",
                   result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 128'(cyc), 128'(e.due));
        end
      end
      done_prev = op_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic push_exp(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t e;
    e.res = 128'(a) * 128'(b);
    e.due = cyc + 1 + W;
    sb.push_back(e);
  endtask

  task automatic issue(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input bit           hold
  );
    multiplier   = a;
    multiplicand = b;
    op_start     = 1'b1;
    op_clear     = 1'b0;
    push_exp(a, b);
    step();
    chk("busy_after_cap", busy, 1);
    if (!hold) op_start = 1'b0;
    multiplier   = rnd();
    multiplicand = rnd();
  endtask

  task automatic clear_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, op_done, 0);
    chk({tag, "_res"}, result, '0);
  endtask

  task automatic clear_pulse();
    op_clear = 1'b1;
    step();
    clear_chk("clr");
    op_clear = 1'b0;
  endtask

  // Controller handshake: clear with start held, then reload.
  task automatic reload(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    multiplier   = a;
    multiplicand = b;
    op_start     = 1'b1;
    op_clear     = 1'b1;
    step();
    clear_chk("reload_clr");
    op_clear = 1'b0;
    push_exp(a, b);
    step();
    chk("reload_busy", busy, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3 * W && !op_done; i++) begin
      step();
    end
    chk("done_timeout", op_done, 1);
  endtask

  initial begin
    logic [2*W-1:0] held;
    logic [W-1:0]   prod;
    int             base;
    int             fac[4];
    reset        = 1'b1;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (2) step();
    chk("rst_done", op_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", result, '0);
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(64'd5, 64'd3, 0);
    wait_done();
    chk("five_three", result, 128'h0F);
    chk("busy_in_done", busy, 0);
    clear_pulse();

    issue('1, '1, 0);
    wait_done();
    clear_pulse();
    issue(64'd0, 64'h1234, 0);
    wait_done();
    clear_pulse();
    issue(64'd1, 64'hDEAD, 0);
    wait_done();
    clear_pulse();

    issue(rnd(), rnd(), 0);
    repeat (29) step();
    op_clear = 1'b1;
    step();
    clear_chk("abort");
    op_clear = 1'b0;
    void'(sb.pop_back());
    repeat (100) step();
    chk("abort_no_done", op_done, 0);

    issue(rnd(), rnd(), 0);
    repeat (20) step();
    reset = 1'b1;
    step();
    clear_chk("midrst");
    reset = 1'b0;
    void'(sb.pop_back());
    repeat (100) step();
    chk("midrst_no_done", op_done, 0);

    issue(64'd7, 64'd9, 1);
    wait_done();
    held = 128'd63;
    repeat (5) step();
    chk("hold_done", op_done, 1);
    chk("hold_res", result, held);
    reload(64'd4, 64'd6);
    wait_done();
    chk("four_six", result, 128'd24);

    base   = n_done;
    fac    = '{5, 4, 3, 2};
    prod   = 64'd1;
    foreach (fac[k]) begin
      reload(prod, 64'(fac[k]));
      wait_done();
      prod = prod * 64'(fac[k]);
    end
    chk("chain_res", result, 128'd120);
    chk("chain_starts", 128'(n_done - base), 128'd4);
    op_start = 1'b0;
    clear_pulse();

    for (int i = 0; i < 8; i++) begin
      issue(rnd(), rnd(), 0);
      wait_done();
      clear_pulse();
    end

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
